// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encoding and line-level constants for the UART transmitter
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte request handshake and serial output between control block and transmitter
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, busy);
    modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: even/odd parity bit over the latched payload
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(parameter int DATA_WIDTH = 8) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);
    always_comb parity = (par_typ == PAR_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: frames a parallel byte into start, LSB-first data, optional parity and stop bits
module uart_tx_frame
    import uart_tx_pkg::*;
#(parameter int DATA_WIDTH = 8) (
    input logic          clk,
    input logic          rst,
    uart_tx_frame_if.slave bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  parity;
    uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data(data_q),
        .par_typ(par_typ_q),
        .parity(parity)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        case (state_q)
            IDLE: if (bus.DATA_VALID) begin
                state_d   = START;
                data_d    = bus.P_DATA;
                par_en_d  = bus.PAR_EN;
                par_typ_d = bus.PAR_TYP;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: if (cnt_q == LAST) begin
                state_d = par_en_q ? PARITY : STOP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            PARITY: state_d = STOP;
            STOP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so the line is clean of input glitches
        tx_d = state_d == START  ? START_BIT :
               state_d == DATA   ? data_q[cnt_d] :
               state_d == PARITY ? parity :
               state_d == STOP   ? STOP_BIT : IDLE_LINE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= IDLE_LINE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed and random frames checked against a bit-list model of the UART frame
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_q[$];
    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_frame #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic build(input logic [7:0] d, input logic pe, input logic pt);
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(1'(($countones(d) % 2) ^ int'(pt)));
        exp_q.push_back(1'b1);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_tx"}, 32'(bus.TX_OUT), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input int inj, input logic [7:0] inj_d, input int abort, input int gap);
        build(d, pe, pt);
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("d%02h_tx[%0d]", d, i), 32'(bus.TX_OUT), 32'(exp_q[i]));
            check($sformatf("d%02h_busy[%0d]", d, i), 32'(bus.busy), 32'd1);
            if (i == abort) begin
                rst = 1'b1;
                bus.DATA_VALID = 1'b1;
                bus.P_DATA = 8'h55;
                step();
                check_idle("abort");
                rst = 1'b0;
                bus.DATA_VALID = 1'b0;
                step();
                check_idle("abort_noacc");
                return;
            end
            bus.DATA_VALID = (i == inj);
            bus.P_DATA = (i == inj) ? inj_d : 8'($urandom);
            bus.PAR_EN = 1'($urandom);
            bus.PAR_TYP = 1'($urandom);
            step();
        end
        bus.DATA_VALID = 1'b0;
        for (int g = 0; g < gap; g++) begin
            check_idle($sformatf("d%02h_gap%0d", d, g));
            if (g < gap - 1) step();
        end
    endtask
    initial begin
        bus.DATA_VALID = 1'b1;
        bus.P_DATA = 8'hAA;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        step();
        check_idle("rst0");
        step();
        check_idle("rst1");
        rst = 1'b0;
        bus.DATA_VALID = 1'b0;
        step();
        check_idle("post_rst");
        send_frame(8'hA5, 1'b0, 1'b0, -1, 8'h00, -1, 2);
        send_frame(8'hA5, 1'b1, 1'b0, -1, 8'h00, -1, 2);
        send_frame(8'hA5, 1'b1, 1'b1, -1, 8'h00, -1, 2);
        send_frame(8'h80, 1'b1, 1'b1, -1, 8'h00, -1, 2);
        send_frame(8'hFF, 1'b0, 1'b0, 4, 8'h3C, -1, 3);
        send_frame(8'hFF, 1'b1, 1'b0, 2, 8'h3C, -1, 1);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 8'h00, -1, 1);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 8'h00, 4, 1);
        send_frame(8'h55, 1'b0, 1'b0, -1, 8'h00, -1, 2);
        for (int k = 0; k < 30; k++)
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
                       8'($urandom), -1, int'($urandom_range(1, 3)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
